pipe_result_collector: RTL and testbench



---
 rtl/pipe_result_collector_pkg.sv | 20 ++
 rtl/pipe_result_collector_if.sv | 30 +++
 rtl/pipe_result_fifo.sv | 56 +++++
 rtl/pipe_result_collector.sv | 78 +++++++
 tb/tb_pipe_result_collector.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_result_collector_pkg.sv
`default_nettype none
// ============================================================================
// pipe_result_collector_pkg : shared widths, pipeline latency, clog2 helper
// Rev 1.0
// ============================================================================
package pipe_result_collector_pkg;

  localparam int c_DATA_WIDTH   = 8;
  // Register count of the extracted i -> r0 -> r1 -> o pipeline.
  localparam int c_PIPE_LATENCY = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_result_collector_if.sv
`default_nettype none
// ============================================================================
// pipe_result_collector_if : upstream sideband, result word and consumer port
// Rev 1.0
// ============================================================================
interface pipe_result_collector_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) ();

  logic                  in_vld;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_vld;
  logic                  dout_rd;
  logic                  full;
  logic [CNT_WIDTH-1:0]  drop_cnt;

  modport master (
    output in_vld, din, dout_rd,
    input  dout, dout_vld, full, drop_cnt
  );

  modport slave (
    input  in_vld, din, dout_rd,
    output dout, dout_vld, full, drop_cnt
  );

endinterface
`default_nettype wire

// File: rtl/pipe_result_fifo.sv
`default_nettype none
// ============================================================================
// pipe_result_fifo : DEPTH x DATA_WIDTH first-word-fall-through FIFO
// Rev 1.0
// ============================================================================
module pipe_result_fifo
  import pipe_result_collector_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_WIDTH-1:0]   din,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic [clog2(DEPTH):0]   occ,
  output logic                    full
);

  localparam int                c_PTR_W    = clog2(DEPTH);
  localparam logic [c_PTR_W:0]  c_FULL_OCC = (c_PTR_W + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_PTR_W:0]      r_occ;

  // The caller guarantees push only when not full (or with a pop) and pop only when non-empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign dout = r_mem[r_rd_ptr];
  assign occ  = r_occ;
  assign full = (r_occ == c_FULL_OCC);

endmodule
`default_nettype wire

// File: rtl/pipe_result_collector.sv
`default_nettype none
// ============================================================================
// pipe_result_collector : aligns in_vld with pipeline results, queues them, counts drops
// Rev 1.0
// ============================================================================
module pipe_result_collector
  import pipe_result_collector_pkg::*;
#(
  parameter int DATA_WIDTH   = c_DATA_WIDTH,
  parameter int PIPE_LATENCY = c_PIPE_LATENCY,
  parameter int DEPTH        = 4,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pipe_result_collector_if.slave   bus
);

  localparam int c_OCC_W = clog2(DEPTH) + 1;

  logic [PIPE_LATENCY-1:0] r_vld_dly;
  logic [CNT_WIDTH-1:0]    r_drop_cnt;
  logic [c_OCC_W-1:0]      w_occ;
  logic [DATA_WIDTH-1:0]   w_dout;
  logic                    w_full;
  logic                    w_vld;
  logic                    w_match;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_drop;

  generate
    if (PIPE_LATENCY == 1) begin : g_dly_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_vld_dly <= '0;
        else        r_vld_dly <= bus.in_vld;
      end
    end else begin : g_dly_shift
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_vld_dly <= '0;
        else        r_vld_dly <= {r_vld_dly[PIPE_LATENCY-2:0], bus.in_vld};
      end
    end
  endgenerate

  assign w_match = r_vld_dly[PIPE_LATENCY-1];
  assign w_vld   = (w_occ != '0);
  assign w_pop   = w_vld & bus.dout_rd;
  // A pop frees the head slot in the same cycle, so a full FIFO can still take the word.
  assign w_push  = w_match & (~w_full | w_pop);
  assign w_drop  = w_match & w_full & ~w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            r_drop_cnt <= '0;
    else if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
  end

  pipe_result_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (bus.din),
    .dout  (w_dout),
    .occ   (w_occ),
    .full  (w_full)
  );

  assign bus.dout     = w_dout;
  assign bus.dout_vld = w_vld;
  assign bus.full     = w_full;
  assign bus.drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_result_collector.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_pipe_result_collector : randomized + directed scoreboard bench, two counter widths
// Rev 1.0
// ============================================================================
module tb_pipe_result_collector;

  localparam int DW    = 8;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_vld = 1'b0;
  logic          rd     = 1'b0;
  logic [DW-1:0] din    = '0;

  pipe_result_collector_if #(.DATA_WIDTH(DW), .CNT_WIDTH(8)) bus ();
  pipe_result_collector_if #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) bus_s ();

  assign bus.in_vld    = in_vld;
  assign bus.din       = din;
  assign bus.dout_rd   = rd;
  assign bus_s.in_vld  = in_vld;
  assign bus_s.din     = din;
  assign bus_s.dout_rd = rd;

  pipe_result_collector #(
    .DATA_WIDTH(DW), .PIPE_LATENCY(LAT), .DEPTH(DEPTH), .CNT_WIDTH(8)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  pipe_result_collector #(
    .DATA_WIDTH(DW), .PIPE_LATENCY(LAT), .DEPTH(DEPTH), .CNT_WIDTH(2)
  ) u_dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: occupancy count, drop tally, expected word order, in_vld history.
  int            occ   = 0;
  int            drops = 0;
  logic [DW-1:0] exp_q[$];
  bit            vld_hist[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    occ   = 0;
    drops = 0;
    exp_q.delete();
    vld_hist.delete();
    for (int i = 0; i < LAT; i++) vld_hist.push_back(1'b0);
  endtask

  // One clock edge of behaviour, using the inputs held during the cycle just ended.
  task automatic model_step();
    bit match;
    bit pop;
    bit accept;
    if (!rst_n) return;
    match = vld_hist.pop_front();
    vld_hist.push_back(in_vld);
    pop    = (occ > 0) && rd;
    accept = match && ((occ < DEPTH) || pop);
    if (match && !accept) drops++;
    if (accept) exp_q.push_back(din);
    occ = occ - int'(pop) + int'(accept);
  endtask

  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r);
    in_vld = v;
    din    = d;
    rd     = r;
    @(posedge clk);
    model_step();
    #2;
  endtask

  function automatic logic [DW-1:0] rnd8();
    return DW'($urandom);
  endfunction

  // Monitor: checks flags every cycle and consumes the scoreboard on each handshake.
  always @(negedge clk) begin
    chk("dout_vld",     32'(bus.dout_vld),   32'(occ != 0));
    chk("full",         32'(bus.full),       32'(occ == DEPTH));
    chk("drop_cnt",     32'(bus.drop_cnt),   32'((drops > 255) ? 255 : drops));
    chk("sat_drop_cnt", 32'(bus_s.drop_cnt), 32'((drops > 3) ? 3 : drops));
    chk("sat_dout_vld", 32'(bus_s.dout_vld), 32'(occ != 0));
    if (bus.dout_vld && exp_q.size() > 0) begin
      chk("dout",     32'(bus.dout),   32'(exp_q[0]));
      chk("sat_dout", 32'(bus_s.dout), 32'(exp_q[0]));
      if (rd) void'(exp_q.pop_front());
    end
  end

  initial begin
    model_reset();
    @(posedge clk);
    #2;

    // Reset held with random activity on the inputs.
    repeat (5) cycle(1'($urandom), rnd8(), 1'($urandom));
    rst_n = 1'b1;
    repeat (3) cycle(1'b0, rnd8(), 1'($urandom));

    // Alignment: one in_vld, matching word two cycles later.
    cycle(1'b1, 8'hFF, 1'b0);
    cycle(1'b0, 8'hFF, 1'b0);
    chk("align_early_vld", 32'(bus.dout_vld), 32'd0);
    cycle(1'b0, 8'h0E, 1'b0);
    chk("align_vld",  32'(bus.dout_vld), 32'd1);
    chk("align_dout", 32'(bus.dout),     32'h0E);
    repeat (2) cycle(1'b0, 8'hFF, 1'b0);
    cycle(1'b0, 8'hFF, 1'b1);
    chk("align_single_word", 32'(bus.dout_vld), 32'd0);
    cycle(1'b0, 8'hFF, 1'b0);

    // Fill and drop: six results into a four-entry FIFO.
    for (int t = 0; t < 6 + LAT; t++)
      cycle(1'(t < 6), (t >= LAT && t < LAT + 6) ? DW'(t - LAT + 1) : 8'hFF, 1'b0);
    chk("fill_full", 32'(bus.full),     32'd1);
    chk("fill_drop", 32'(bus.drop_cnt), 32'd2);

    // Full FIFO, match and pop in the same cycle.
    cycle(1'b1, 8'hFF, 1'b0);
    cycle(1'b0, 8'hFF, 1'b0);
    cycle(1'b0, 8'h55, 1'b1);
    chk("fullpop_full", 32'(bus.full),     32'd1);
    chk("fullpop_drop", 32'(bus.drop_cnt), 32'd2);
    repeat (6) cycle(1'b0, 8'hFF, 1'b1);
    chk("fullpop_drained", 32'(bus.dout_vld), 32'd0);

    // Randomized traffic.
    repeat (1500) cycle(1'($urandom_range(0, 99) < 55), rnd8(), 1'($urandom_range(0, 99) < 60));
    repeat (8) cycle(1'b0, rnd8(), 1'b1);

    // Back-to-back throughput with the consumer always ready.
    repeat (40) cycle(1'b1, rnd8(), 1'b1);
    repeat (4) cycle(1'b0, rnd8(), 1'b1);

    // Saturation of both counters.
    repeat (300) cycle(1'b1, rnd8(), 1'b0);
    chk("sat_big",   32'(bus.drop_cnt),   32'd255);
    chk("sat_small", 32'(bus_s.drop_cnt), 32'd3);
    repeat (3) cycle(1'b1, rnd8(), 1'b0);
    chk("sat_big_hold",   32'(bus.drop_cnt),   32'd255);
    chk("sat_small_hold", 32'(bus_s.drop_cnt), 32'd3);
    repeat (8) cycle(1'b0, rnd8(), 1'b1);

    // Asynchronous reset with three words queued and one still in flight.
    repeat (4) cycle(1'b1, rnd8(), 1'b0);
    cycle(1'b0, rnd8(), 1'b0);
    chk("pre_reset_vld", 32'(bus.dout_vld), 32'd1);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_vld",  32'(bus.dout_vld), 32'd0);
    chk("async_rst_full", 32'(bus.full),     32'd0);
    chk("async_rst_drop", 32'(bus.drop_cnt), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (6) cycle(1'b0, rnd8(), 1'b0);
    chk("no_stale_push", 32'(bus.dout_vld), 32'd0);

    repeat (200) cycle(1'($urandom_range(0, 99) < 70), rnd8(), 1'($urandom_range(0, 99) < 50));
    repeat (8) cycle(1'b0, rnd8(), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
